// File: rtl/dbus_ctrl.sv
// dbus_ctrl: memory-stage controller issuing one data-bus transaction per access
// and returning the lane-extracted, extended load result (rev 1.0).
`default_nettype none

package dbus_ctrl_pkg;
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;
endpackage

module dbus_ctrl
  import dbus_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  msize_t      req_msize,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_strobe,
  input  logic        req_sext,
  input  logic        req_misalign,
  input  logic        stage_advance,
  input  logic        flush,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        stall,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_exc
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_ADDR = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_HOLD      = 3'd3,
    S_DRAIN     = 3'd4
  } state_t;

  state_t      state_q,      state_d;
  logic        dreq_valid_q, dreq_valid_d;
  logic [63:0] addr_q,       addr_d;
  msize_t      size_q,       size_d;
  logic [7:0]  strobe_q,     strobe_d;
  logic [63:0] wdata_q,      wdata_d;
  logic        sext_q,       sext_d;
  logic        write_q,      write_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_exc_q,   resp_exc_d;

  logic [63:0] shifted;
  logic [63:0] load_ext;
  logic [63:0] bus_result;

  // Bring the addressed byte lane down to bit 0, then truncate and extend.
  always_comb begin
    shifted = dresp_data >> {addr_q[2:0], 3'b000};
    case (size_q)
      MSIZE1:  load_ext = {{56{sext_q & shifted[7]}},  shifted[7:0]};
      MSIZE2:  load_ext = {{48{sext_q & shifted[15]}}, shifted[15:0]};
      MSIZE4:  load_ext = {{32{sext_q & shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
    bus_result = write_q ? 64'd0 : load_ext;
  end

  always_comb begin
    state_d      = state_q;
    dreq_valid_d = dreq_valid_q;
    addr_d       = addr_q;
    size_d       = size_q;
    strobe_d     = strobe_q;
    wdata_d      = wdata_q;
    sext_d       = sext_q;
    write_d      = write_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_exc_d   = resp_exc_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          if (req_misalign) begin
            state_d      = S_HOLD;
            resp_valid_d = 1'b1;
            resp_exc_d   = 1'b1;
            resp_rdata_d = 64'd0;
          end else begin
            state_d      = S_WAIT_ADDR;
            dreq_valid_d = 1'b1;
            addr_d       = req_addr;
            size_d       = req_msize;
            strobe_d     = req_strobe;
            wdata_d      = req_wdata;
            sext_d       = req_sext;
            write_d      = req_write;
          end
        end
      end

      // A data_ok seen before addr_ok completes both phases at once.
      S_WAIT_ADDR, S_WAIT_DATA: begin
        if (dresp_data_ok) begin
          dreq_valid_d = 1'b0;
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            state_d      = S_HOLD;
            resp_valid_d = 1'b1;
            resp_exc_d   = 1'b0;
            resp_rdata_d = bus_result;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end else if (state_q == S_WAIT_ADDR && dresp_addr_ok) begin
          state_d = S_WAIT_DATA;
        end
      end

      S_HOLD: begin
        if (flush || stage_advance) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          resp_exc_d   = 1'b0;
          resp_rdata_d = 64'd0;
        end
      end

      // The bus cannot be cancelled mid-flight; let it finish and drop the data.
      S_DRAIN: begin
        if (dresp_data_ok) begin
          state_d      = S_IDLE;
          dreq_valid_d = 1'b0;
        end
      end

      default: begin
        state_d      = S_IDLE;
        dreq_valid_d = 1'b0;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      dreq_valid_q <= 1'b0;
      addr_q       <= 64'd0;
      size_q       <= MSIZE1;
      strobe_q     <= 8'd0;
      wdata_q      <= 64'd0;
      sext_q       <= 1'b0;
      write_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_exc_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dreq_valid_q <= dreq_valid_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      strobe_q     <= strobe_d;
      wdata_q      <= wdata_d;
      sext_q       <= sext_d;
      write_q      <= write_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_exc_q   <= resp_exc_d;
    end
  end

  assign dreq_valid  = dreq_valid_q;
  assign dreq_addr   = addr_q;
  assign dreq_size   = {1'b0, size_q};
  assign dreq_strobe = strobe_q;
  assign dreq_data   = wdata_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_exc    = resp_exc_q;

  // Gated by resetn so stall is forced low while reset is held.
  assign stall = resetn & ((state_q == S_DRAIN) | (req_valid & (state_q != S_HOLD)));

endmodule

`default_nettype wire

// File: tb/tb_dbus_ctrl.sv
// tb_dbus_ctrl: randomized and directed checks of dbus_ctrl against a timeline model.
`default_nettype none

module tb_dbus_ctrl;
  import dbus_ctrl_pkg::*;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  msize_t      req_msize;
  logic [63:0] req_wdata;
  logic [7:0]  req_strobe;
  logic        req_sext;
  logic        req_misalign;
  logic        stage_advance;
  logic        flush;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        stall;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_exc;

  int n_total;
  int n_bad;

  dbus_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_msize     (req_msize),
    .req_wdata     (req_wdata),
    .req_strobe    (req_strobe),
    .req_sext      (req_sext),
    .req_misalign  (req_misalign),
    .stage_advance (stage_advance),
    .flush         (flush),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .stall         (stall),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_exc      (resp_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected load result from plain byte arithmetic.
  function automatic logic [63:0] ref_load(input logic [63:0] data, input logic [2:0] off,
                                           input logic [1:0] sz, input bit sx);
    logic [63:0] v;
    logic [63:0] mask;
    int nb;
    v  = data >> (8 * int'(off));
    nb = 1 << sz;
    if (nb < 8) begin
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v = v & mask;
      if (sx && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic idle_inputs();
    req_valid     = 1'b0;
    req_write     = 1'b0;
    req_addr      = 64'd0;
    req_msize     = MSIZE1;
    req_wdata     = 64'd0;
    req_strobe    = 8'd0;
    req_sext      = 1'b0;
    req_misalign  = 1'b0;
    stage_advance = 1'b0;
    flush         = 1'b0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = 64'd0;
  endtask

  // Cycle 0 presents the request. a = addr_ok cycle (none if > d), d = data_ok cycle
  // (0 for misaligned), f = flush cycle (-1 none), s = stage_advance cycle.
  task automatic run_txn(input bit wr, input bit mis, input logic [63:0] addr,
                         input logic [1:0] sz, input bit sx, input logic [63:0] wd,
                         input logic [7:0] sb, input int a, input int d, input int f,
                         input int s, input logic [63:0] rdat);
    int last_req;
    int kend;
    bit acc;
    bit bus;
    bit killed;
    bit dv;
    bit rv;
    bit drn;
    bit rqv;
    logic [63:0] exp_rd;
    acc      = (f != 0);
    bus      = acc && !mis;
    killed   = (f >= 0) && (f <= d);
    last_req = (f >= 0) ? f : s;
    kend     = ((d > last_req) ? d : last_req) + 2;
    exp_rd   = (wr || mis) ? 64'd0 : ref_load(rdat, addr[2:0], sz, sx);
    for (int k = 0; k <= kend; k++) begin
      @(negedge clk);
      rqv           = (k <= last_req);
      req_valid     = rqv;
      req_write     = wr;
      req_addr      = addr;
      req_msize     = msize_t'(sz);
      req_wdata     = wd;
      req_strobe    = sb;
      req_sext      = sx;
      req_misalign  = mis;
      flush         = (k == f);
      stage_advance = (f < 0) && (k == s);
      dresp_addr_ok = bus && (k == a) && (k >= 1) && (k <= d);
      dresp_data_ok = bus && (k == d);
      dresp_data    = (bus && k == d) ? rdat : {$urandom, $urandom};
      #1;
      dv  = bus && (k >= 1) && (k <= d);
      rv  = acc && !killed && (k >= d + 1) && (k <= last_req);
      drn = bus && (f >= 1) && (f < d) && (k > f) && (k <= d);
      chk("dreq_valid", 64'(dreq_valid), 64'(dv));
      chk("resp_valid", 64'(resp_valid), 64'(rv));
      chk("stall", 64'(stall), 64'(drn | (rqv & !rv)));
      if (dv) begin
        chk("dreq_addr", dreq_addr, addr);
        chk("dreq_size", 64'(dreq_size), 64'({1'b0, sz}));
        chk("dreq_strobe", 64'(dreq_strobe), 64'(sb));
        chk("dreq_data", dreq_data, wd);
      end
      if (rv) begin
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_exc", 64'(resp_exc), 64'(mis));
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic reset_mid_txn();
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 64'h0000_0000_0000_3008;
    req_msize = MSIZE8;
    @(negedge clk);
    chk("rst_pre_dv", 64'(dreq_valid), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_dv", 64'(dreq_valid), 64'd0);
    chk("rst_daddr", dreq_addr, 64'd0);
    chk("rst_dsize", 64'(dreq_size), 64'd0);
    chk("rst_dstrb", 64'(dreq_strobe), 64'd0);
    chk("rst_ddata", dreq_data, 64'd0);
    chk("rst_rv", 64'(resp_valid), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_exc", 64'(resp_exc), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    req_valid     = 1'b0;
    resetn        = 1'b1;
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rel_dv", 64'(dreq_valid), 64'd0);
    chk("rel_rv", 64'(resp_valid), 64'd0);
    chk("rel_stall", 64'(stall), 64'd0);
  endtask

  initial begin
    bit wr;
    bit mis;
    bit sx;
    logic [1:0] sz;
    logic [7:0] sb;
    int a;
    int d;
    int f;
    int s;
    n_total = 0;
    n_bad   = 0;
    idle_inputs();
    resetn = 1'b0;
    #1;
    chk("reset_dv", 64'(dreq_valid), 64'd0);
    chk("reset_rv", 64'(resp_valid), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_rdata", resp_rdata, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Byte load with sign extension, both handshakes in the first bus cycle.
    run_txn(1'b0, 1'b0, 64'h1003, 2'd0, 1'b1, 64'd0, 8'h00, 1, 1, -1, 3,
            64'h0000_0000_8000_0000);
    // Word store with addr_ok in cycle 3 and data_ok in cycle 5.
    run_txn(1'b1, 1'b0, 64'h2004, 2'd2, 1'b0, 64'hDEAD_BEEF_0000_0000, 8'hF0, 3, 5, -1, 6,
            64'h1234_5678_9ABC_DEF0);
    // Misaligned doubleword load.
    run_txn(1'b0, 1'b1, 64'h3003, 2'd3, 1'b0, 64'd0, 8'h00, -1, 0, -1, 2, 64'd0);
    // Flush in WAIT_DATA, data_ok three cycles later.
    run_txn(1'b0, 1'b0, 64'h4000, 2'd3, 1'b0, 64'd0, 8'h00, 1, 5, 2, 7,
            64'hCAFE_F00D_0BAD_BEEF);
    // data_ok without any addr_ok; flush together with data_ok.
    run_txn(1'b0, 1'b0, 64'h5006, 2'd1, 1'b1, 64'd0, 8'h00, 9, 2, -1, 4,
            64'h8001_0000_0000_0000);
    run_txn(1'b0, 1'b0, 64'h6000, 2'd2, 1'b0, 64'd0, 8'h00, 1, 3, 3, 5, 64'd7);

    for (int i = 0; i < 60; i++) begin
      mis = ($urandom_range(0, 7) == 0);
      wr  = 1'($urandom_range(0, 1));
      sx  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      sb  = wr ? (8'($urandom) | 8'h01) : 8'h00;
      if (mis) begin
        d = 0;
        a = -1;
      end else begin
        d = $urandom_range(1, 5);
        a = $urandom_range(1, d + 1);
      end
      f = ($urandom_range(0, 9) < 6) ? -1 : $urandom_range(0, d + 3);
      s = d + $urandom_range(1, 3);
      run_txn(wr, mis, {$urandom, $urandom}, sz, sx, {$urandom, $urandom}, sb,
              a, d, f, s, {$urandom, $urandom});
    end

    reset_mid_txn();
    run_txn(1'b0, 1'b0, 64'h7001, 2'd0, 1'b0, 64'd0, 8'h00, 1, 2, -1, 3,
            64'h0000_0000_0000_A500);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dbus_ctrl.md
DBUS_CTRL -- requirements
Module: dbus_ctrl

Interface
REQ-001 Clock and reset SHALL be one clock with asynchronous active-low reset: ports clk, resetn.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  memory-stage access request, held until resp consumed.
REQ-005 req_write  in  1  1=store, 0=load.
REQ-006 req_addr  in  64  byte address.
REQ-007 req_msize  in  msize_t  MSIZE1/2/4/8.
REQ-008 req_wdata  in  64  lane-aligned store data, already shifted to byte lane.
REQ-009 req_strobe  in  8  lane-aligned byte strobe; 0 for loads.
REQ-010 req_sext  in  1  load result sign-extended when 1, zero-extended when 0.
REQ-011 req_misalign  in  1  alignment exception from store/load lane logic.
REQ-012 stage_advance  in  1  downstream consumes resp this cycle.
REQ-013 flush  in  1  discard current request and result.
REQ-014 dreq_valid/dreq_addr/dreq_size/dreq_strobe/dreq_data  out  1/64/3/8/64  data-bus request.
REQ-015 dresp_addr_ok/dresp_data_ok  in  1/1; dresp_data  in  64  data-bus response.
REQ-016 stall  out  1  pipeline stall request; resp_valid  out  1; resp_rdata  out  64; resp_exc  out  1.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_ADDR, WAIT_DATA, HOLD, DRAIN.
REQ-018 IDLE, req_valid=1, flush=0, req_misalign=0: latch addr/size/strobe/data/sext; -> WAIT_ADDR; dreq_valid=1 from next cycle.
REQ-019 IDLE, req_valid=1, req_misalign=1: no bus request; -> HOLD with resp_exc=1, resp_rdata=0.
REQ-020 dreq_* SHALL be driven from registers only, stable while dreq_valid=1; dreq_valid held until the data_ok cycle.
REQ-021 WAIT_ADDR: addr_ok&data_ok same cycle -> HOLD; addr_ok only -> WAIT_DATA; data_ok without prior addr_ok treated as both.
REQ-022 WAIT_DATA: data_ok -> HOLD; dreq_valid deasserts the cycle after data_ok.
REQ-023 On data_ok for a load: resp_rdata = dresp_data >> (8*addr[2:0]), truncated to msize bytes, then sign- or zero-extended per sext; for stores resp_rdata=0.
REQ-024 HOLD: resp_valid=1; stage_advance=1 -> IDLE (new request not accepted that same cycle).
REQ-025 stall SHALL be 1 whenever req_valid=1 and (state != HOLD or resp not yet registered), and 0 in HOLD and in IDLE with req_valid=0.
REQ-026 flush in IDLE or HOLD -> IDLE, resp_valid=0 next cycle.
REQ-027 flush in WAIT_ADDR/WAIT_DATA SHALL NOT cancel the bus transaction: -> DRAIN, keep dreq stable, wait data_ok, discard data, -> IDLE; stall=1 in DRAIN.
REQ-028 flush and data_ok in the same cycle -> IDLE directly, result discarded.
REQ-029 Exactly one bus transaction per accepted aligned request; none for misaligned or flushed-in-IDLE requests.

Reset
REQ-030 resetn=0 SHALL asynchronously force IDLE, dreq_valid=0, dreq_addr/size/strobe/data=0, resp_valid=0, resp_rdata=0, resp_exc=0, stall=0.
REQ-031 Reset mid-transaction SHALL abandon it; no data_ok recovery after reset deassertion.

Verification
REQ-032 Load MSIZE1, addr 0x1003, sext=1, dresp_data=0x00000000_80000000 with addr_ok+data_ok in first request cycle -> resp_rdata=0xFFFF_FFFF_FFFF_FF80, resp_valid 2 cycles after req_valid.
REQ-033 Store MSIZE4, addr 0x2004, strobe 0xF0, wdata 0xDEADBEEF_00000000; addr_ok cycle 3, data_ok cycle 5 -> dreq fields stable cycles 1-5, one transaction, resp_rdata=0.
REQ-034 Load MSIZE8 with req_misalign=1 -> dreq_valid never 1, resp_exc=1 next cycle, stall=0 in HOLD.
REQ-035 Flush in WAIT_DATA, data_ok 3 cycles later -> DRAIN, stall=1 throughout, resp_valid stays 0, IDLE after data_ok.
REQ-036 resetn low during WAIT_ADDR -> dreq_valid=0 immediately (asynchronously), all outputs 0, IDLE on release.
